ps2_mouse_receiver: RTL and testbench

Receives the PS/2 mouse device-to-host bitstream, assembles standard 3-byte stream-mode packets, and drives the pointer interface consumed by the game board: `pointer_ready`, `pointer_delta_x`, `pointer_delta_y` and `pointer_select`. It sits between the board's PS/2 pins and the life-game logic, in the same clock domain. It converts device deltas to sign-magnitude screen-space motion and turns the left-button press into a single-cycle cell-toggle pulse.

---
 rtl/ps2_mouse_receiver.sv | 227 ++++++++++++++++++++++
 tb/tb_ps2_mouse_receiver.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_receiver.sv
// PS/2 mouse receiver: synchronizes and filters the PS/2 pins, deframes bytes,
// assembles 3-byte stream packets and drives sign-magnitude pointer deltas.
// Optional idle timeout is enabled with `define PS2_MOUSE_RECEIVER_TIMEOUT_EN.
module ps2_mouse_receiver #(
    parameter int unsigned FILTER_DEPTH   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       ps2_clock,
    input  logic       ps2_data,
    output logic       pointer_ready,
    output logic [8:0] pointer_delta_x,
    output logic [8:0] pointer_delta_y,
    output logic       pointer_select,
    output logic [2:0] pointer_buttons,
    output logic       frame_error
);

    localparam int unsigned FW = $clog2(FILTER_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]    clk_sync_q, dat_sync_q;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic          filt_q, filt_d;
    logic          fall;
    logic          bit_in;

    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_err_q, par_err_d;
    logic [1:0]    idx_q, idx_d;
    // Header byte minus its always-one bit 3: {Yovf, Xovf, Ysign, Xsign, M, R, L}
    logic [6:0]    hdr_q, hdr_d;
    logic [7:0]    xbyte_q, xbyte_d;

    logic          ready_q, ready_d;
    logic          sel_q, sel_d;
    logic          err_q, err_d;
    logic [8:0]    dx_q, dx_d;
    logic [8:0]    dy_q, dy_d;
    logic [2:0]    btn_q, btn_d;

    function automatic logic [8:0] conv_delta(input logic sgn, input logic ovf,
                                              input logic [7:0] b, input logic flip);
        logic [7:0] mag;
        logic       s;
        if (ovf)
            mag = 8'hFF;
        else if (!sgn)
            mag = b;
        else if (b == 8'h00)
            mag = 8'hFF;
        else
            mag = ~b + 8'd1;
        s = sgn ^ flip;
        if (mag == 8'h00)
            s = 1'b0;
        return {s, mag};
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clock};
            dat_sync_q <= {dat_sync_q[0], ps2_data};
        end
    end

    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_sync_q[1] != filt_q) begin
            if (filt_cnt_q == FW'(FILTER_DEPTH - 1))
                filt_d = clk_sync_q[1];
            else
                filt_cnt_d = filt_cnt_q + 1'b1;
        end
    end

    assign fall   = filt_q & ~filt_d;
    assign bit_in = dat_sync_q[1];

`ifdef PS2_MOUSE_RECEIVER_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt_q, to_cnt_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            to_cnt_q <= '0;
        else
            to_cnt_q <= to_cnt_d;
    end
`endif

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_err_d = par_err_q;
        idx_d     = idx_q;
        hdr_d     = hdr_q;
        xbyte_d   = xbyte_q;
        ready_d   = 1'b0;
        sel_d     = 1'b0;
        err_d     = 1'b0;
        dx_d      = dx_q;
        dy_d      = dy_q;
        btn_d     = btn_q;
`ifdef PS2_MOUSE_RECEIVER_TIMEOUT_EN
        to_cnt_d  = '0;
`endif

        if (fall) begin
            unique case (state_q)
                IDLE: begin
                    if (!bit_in) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d   = {bit_in, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7)
                        state_d = PARITY;
                end
                PARITY: begin
                    par_err_d = ~(^shift_q ^ bit_in);
                    state_d   = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (bit_in && !par_err_q) begin
                        unique case (idx_q)
                            2'd0: begin
                                if (shift_q[3]) begin
                                    hdr_d = {shift_q[7:4], shift_q[2:0]};
                                    idx_d = 2'd1;
                                end else begin
                                    err_d = 1'b1;
                                end
                            end
                            2'd1: begin
                                xbyte_d = shift_q;
                                idx_d   = 2'd2;
                            end
                            2'd2: begin
                                idx_d   = 2'd0;
                                ready_d = 1'b1;
                                dx_d    = conv_delta(hdr_q[3], hdr_q[5], xbyte_q, 1'b0);
                                dy_d    = conv_delta(hdr_q[4], hdr_q[6], shift_q, 1'b1);
                                btn_d   = hdr_q[2:0];
                                sel_d   = hdr_q[0] & ~btn_q[0];
                            end
                            default: idx_d = 2'd0;
                        endcase
                    end else begin
                        err_d = 1'b1;
                        idx_d = 2'd0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
`ifdef PS2_MOUSE_RECEIVER_TIMEOUT_EN
        // The counter only advances between edges, so it never collides with a stop-bit commit
        else if (state_q != IDLE || idx_q != 2'd0) begin
            if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_d = IDLE;
                idx_d   = 2'd0;
                err_d   = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_err_q  <= 1'b0;
            idx_q      <= '0;
            hdr_q      <= '0;
            xbyte_q    <= '0;
            ready_q    <= 1'b0;
            sel_q      <= 1'b0;
            err_q      <= 1'b0;
            dx_q       <= '0;
            dy_q       <= '0;
            btn_q      <= '0;
        end else begin
            filt_q     <= filt_d;
            filt_cnt_q <= filt_cnt_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_err_q  <= par_err_d;
            idx_q      <= idx_d;
            hdr_q      <= hdr_d;
            xbyte_q    <= xbyte_d;
            ready_q    <= ready_d;
            sel_q      <= sel_d;
            err_q      <= err_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            btn_q      <= btn_d;
        end
    end

    assign pointer_ready   = ready_q;
    assign pointer_select  = sel_q;
    assign frame_error     = err_q;
    assign pointer_delta_x = dx_q;
    assign pointer_delta_y = dy_q;
    assign pointer_buttons = btn_q;

endmodule

// File: tb/tb_ps2_mouse_receiver.sv
// Scoreboard bench for ps2_mouse_receiver: a packet-level reference model queues
// expected ready/error events and a monitor compares them as the DUT pulses.
module tb_ps2_mouse_receiver;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_clock = 1'b1;
    logic       ps2_data = 1'b1;
    logic       pointer_ready;
    logic [8:0] pointer_delta_x;
    logic [8:0] pointer_delta_y;
    logic       pointer_select;
    logic [2:0] pointer_buttons;
    logic       frame_error;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit         is_err;
        logic [8:0] dx;
        logic [8:0] dy;
        bit         sel;
        logic [2:0] btn;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] pkt[$];
    bit         prev_l = 1'b0;
    logic [8:0] last_dx = '0;
    logic [8:0] last_dy = '0;
    logic [2:0] last_btn = '0;
    ev_t        mon_e;

    always #5 clock = ~clock;

    ps2_mouse_receiver #(
        .FILTER_DEPTH  (4),
        .TIMEOUT_CYCLES(200)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ps2_clock      (ps2_clock),
        .ps2_data       (ps2_data),
        .pointer_ready  (pointer_ready),
        .pointer_delta_x(pointer_delta_x),
        .pointer_delta_y(pointer_delta_y),
        .pointer_select (pointer_select),
        .pointer_buttons(pointer_buttons),
        .frame_error    (frame_error)
    );

    // Screen-space motion from the device's signed delta, using integer arithmetic
    function automatic logic [8:0] ref_delta(input bit sgn, input bit ovf,
                                             input logic [7:0] b, input bit is_y);
        int raw;
        int mag;
        bit neg;
        bit s;
        raw = sgn ? int'(b) - 256 : int'(b);
        neg = (raw < 0);
        mag = neg ? -raw : raw;
        if (mag > 255) mag = 255;
        if (ovf) mag = 255;
        s = is_y ? !neg : neg;
        if (mag == 0) s = 1'b0;
        return {s, 8'(mag)};
    endfunction

    task automatic push_err();
        ev_t e;
        e.is_err = 1'b1; e.dx = '0; e.dy = '0; e.sel = 1'b0; e.btn = '0;
        exp_q.push_back(e);
    endtask

    task automatic model_byte(input logic [7:0] b, input bit good);
        ev_t e;
        if (!good) begin
            push_err();
            pkt.delete();
        end else if (pkt.size() == 0 && !b[3]) begin
            push_err();
        end else begin
            pkt.push_back(b);
            if (pkt.size() == 3) begin
                e.is_err = 1'b0;
                e.dx  = ref_delta(pkt[0][4], pkt[0][6], pkt[1], 1'b0);
                e.dy  = ref_delta(pkt[0][5], pkt[0][7], pkt[2], 1'b1);
                e.btn = pkt[0][2:0];
                e.sel = pkt[0][0] && !prev_l;
                prev_l   = pkt[0][0];
                last_dx  = e.dx;
                last_dy  = e.dy;
                last_btn = e.btn;
                exp_q.push_back(e);
                pkt.delete();
            end
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic ps2_bit(input logic v);
        ps2_data = v;
        wait_cyc(5);
        ps2_clock = 1'b0;
        wait_cyc(10);
        ps2_clock = 1'b1;
        wait_cyc(5);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic [10:0] bits;
        model_byte(b, !(bad_par || bad_stop));
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++)
            ps2_bit(bits[i]);
        ps2_data = 1'b1;
        wait_cyc(10);
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_byte(b0, 1'b0, 1'b0);
        send_byte(b1, 1'b0, 1'b0);
        send_byte(b2, 1'b0, 1'b0);
    endtask

    task automatic check_outputs(input string name);
        logic [23:0] got;
        logic [23:0] want;
        got  = {pointer_ready, pointer_select, frame_error, pointer_buttons, pointer_delta_x, pointer_delta_y};
        want = {3'b000, last_btn, last_dx, last_dy};
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    always @(negedge clock) begin
        if (reset_n) begin
            if (pointer_select && !pointer_ready) begin
                total++;
                bad++;
                $display("FAIL select_without_ready sel=%b ready=%b", pointer_select, pointer_ready);
            end
            if (pointer_ready || frame_error) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_event ready=%b err=%b want no event", pointer_ready, frame_error);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.is_err) begin
                        if (!(frame_error && !pointer_ready)) begin
                            bad++;
                            $display("FAIL error_event got ready=%b err=%b want ready=0 err=1",
                                     pointer_ready, frame_error);
                        end
                    end else if (!(pointer_ready && !frame_error && pointer_delta_x === mon_e.dx &&
                                   pointer_delta_y === mon_e.dy && pointer_select === mon_e.sel &&
                                   pointer_buttons === mon_e.btn)) begin
                        bad++;
                        $display("FAIL ready_event got rdy=%b err=%b dx=%h dy=%h sel=%b btn=%b want dx=%h dy=%h sel=%b btn=%b",
                                 pointer_ready, frame_error, pointer_delta_x, pointer_delta_y,
                                 pointer_select, pointer_buttons, mon_e.dx, mon_e.dy, mon_e.sel, mon_e.btn);
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] b;
        int         r;

        wait_cyc(5);
        reset_n = 1'b1;
        wait_cyc(3);
        check_outputs("reset_state");

        // Short clock glitch with data low must not look like a start bit
        ps2_data  = 1'b0;
        ps2_clock = 1'b0;
        wait_cyc(3);
        ps2_clock = 1'b1;
        ps2_data  = 1'b1;
        wait_cyc(20);
        check_outputs("after_glitch");

        send_pkt(8'h09, 8'h05, 8'h03);
        send_pkt(8'h39, 8'hFB, 8'h00);
        check_outputs("hold_after_packet");
        send_byte(8'h08, 1'b0, 1'b0);
        send_byte(8'h12, 1'b1, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        send_pkt(8'h08, 8'h00, 8'h00);
        send_pkt(8'h58, 8'h10, 8'h20);
        send_pkt(8'hA9, 8'h7F, 8'hFF);
        send_byte(8'h0B, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b1);
        send_pkt(8'h0D, 8'h80, 8'h01);

        // Reset in the middle of a frame after two good bytes
        send_byte(8'h09, 1'b0, 1'b0);
        send_byte(8'h44, 1'b0, 1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        reset_n = 1'b0;
        pkt.delete();
        prev_l = 1'b0; last_dx = '0; last_dy = '0; last_btn = '0;
        wait_cyc(2);
        check_outputs("mid_frame_reset");
        ps2_data = 1'b1;
        reset_n  = 1'b1;
        wait_cyc(30);
        send_pkt(8'h09, 8'h01, 8'hFF);

        for (int n = 0; n < 90; n++) begin
            b = 8'($urandom);
            r = int'($urandom_range(0, 19));
            if (pkt.size() == 0 && r > 1) b[3] = 1'b1;
            send_byte(b, r == 0, r == 1);
        end

        // Partial packet followed by a long idle gap
        if (pkt.size() != 0) send_byte(8'h00, 1'b1, 1'b0);
        send_byte(8'h08, 1'b0, 1'b0);
        send_byte(8'h05, 1'b0, 1'b0);
`ifdef PS2_MOUSE_RECEIVER_TIMEOUT_EN
        push_err();
        pkt.delete();
`endif
        wait_cyc(300);
        send_pkt(8'h0A, 8'h07, 8'h09);
        send_pkt(8'h1C, 8'hF0, 8'h30);

        wait_cyc(100);
        check_outputs("final_hold");
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL pending_events got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
